// File: rtl/mdio_init_seq.sv
// Power-up MDIO register initialisation: waits for the PHY to settle, then writes
// a fixed 4-entry table through an external MDIO write engine, with timeout detection.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | just out of reset, arms the power-up timer
// S_PWR_WAIT | waiting PWRUP_CYC mdc cycles for the PHY to come up
// S_LOAD     | frame word presented, start low for 2 cycles to clear engine
// S_RUN      | start high, waiting for tr_end or timeout
// S_GAP      | idle spacing between consecutive writes
// S_DONE     | whole table written
// S_ERR      | engine timed out on entry cur_idx
`timescale 1ns/1ps
module mdio_init_seq #(
  parameter int unsigned PWRUP_CYC = 2000,
  parameter int unsigned GAP_CYC   = 4,
  parameter int unsigned TMO_CYC   = 48
) (
  input  logic        mdc,
  input  logic        reset_n,
  input  logic        restart,
  output logic        start,
  output logic [23:0] mdio_data,
  input  logic        tr_end,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  cur_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_PWR_WAIT, S_LOAD, S_RUN, S_GAP, S_DONE, S_ERR
  } state_t;

  localparam logic [15:0] PWRUP_LD = 16'(PWRUP_CYC - 1);
  localparam logic [15:0] GAP_LD   = 16'(GAP_CYC - 1);
  localparam logic [15:0] TMO_LD   = 16'(TMO_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] data_q, data_d;
  logic        load_go;
  logic [1:0]  load_idx;
  logic        cnt_zero;

  function automatic logic [20:0] rom_word(input logic [1:0] idx);
    case (idx)
      2'd0:    rom_word = {5'h00, 16'h9140};
      2'd1:    rom_word = {5'h14, 16'h0CE2};
      2'd2:    rom_word = {5'h1B, 16'h848B};
      default: rom_word = {5'h00, 16'h9140};
    endcase
  endfunction

  assign cnt_zero = (cnt_q == 16'd0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    load_go  = 1'b0;
    load_idx = 2'd0;
    case (state_q)
      S_IDLE: begin
        state_d = S_PWR_WAIT;
        cnt_d   = PWRUP_LD;
      end
      S_PWR_WAIT: begin
        if (cnt_zero) load_go = 1'b1;
        else          cnt_d   = cnt_q - 16'd1;
      end
      S_LOAD: begin
        if (cnt_zero) begin
          state_d = S_RUN;
          cnt_d   = TMO_LD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_RUN: begin
        // completion takes priority over a timeout landing on the same cycle
        if (tr_end) begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
        end else if (cnt_zero) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_GAP: begin
        if (cnt_zero) begin
          if (idx_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            load_go  = 1'b1;
            load_idx = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DONE, S_ERR: begin
        if (restart) load_go = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // every path into LOAD latches the next frame word here, and only here
    if (load_go) begin
      state_d = S_LOAD;
      idx_d   = load_idx;
      cnt_d   = 16'd1;
      data_d  = {3'b000, rom_word(load_idx)};
    end
  end

  always_ff @(posedge mdc or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 2'd0;
      data_q  <= 24'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign start     = (state_q == S_RUN);
  assign busy      = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign cur_idx   = idx_q;
  assign mdio_data = data_q;

endmodule

// File: tb/tb_mdio_init_seq.sv
// Randomised bench for mdio_init_seq: an MDIO engine model with random completion
// latency, and a per-cycle expected-output schedule built from the sequencing rules.
`timescale 1ns/1ps
module tb_mdio_init_seq;
  localparam int PWRUP = 10;
  localparam int GAP   = 4;
  localparam int TMO   = 48;
  localparam int NEVER = 100000;

  logic        mdc = 1'b0;
  logic        reset_n = 1'b0;
  logic        restart = 1'b0;
  logic        tr_end = 1'b0;
  logic        start, busy, done, err;
  logic [23:0] mdio_data;
  logic [1:0]  cur_idx;

  int checks = 0;
  int failures = 0;

  mdio_init_seq #(.PWRUP_CYC(PWRUP), .GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
    .mdc(mdc), .reset_n(reset_n), .restart(restart), .start(start),
    .mdio_data(mdio_data), .tr_end(tr_end), .busy(busy), .done(done),
    .err(err), .cur_idx(cur_idx)
  );

  initial forever #25 mdc = ~mdc;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] word(input int i);
    case (i)
      0:       word = {3'b000, 5'h00, 16'h9140};
      1:       word = {3'b000, 5'h14, 16'h0CE2};
      2:       word = {3'b000, 5'h1B, 16'h848B};
      default: word = {3'b000, 5'h00, 16'h9140};
    endcase
  endfunction

  // engine: tr_end rises lat negedges after start rises, cleared once start is low;
  // in stale mode the clear is delayed until the second LOAD cycle
  int  lat_q[$];
  bit  stale_mode = 1'b0;
  initial begin
    int  cyc, cur_lat, low_cnt;
    bit  seen;
    cyc = 0; cur_lat = NEVER; low_cnt = 0; seen = 1'b0;
    forever begin
      @(negedge mdc);
      if (start === 1'b1) begin
        if (!seen) begin
          seen = 1'b1;
          cyc = 0;
          cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : NEVER;
        end
        cyc++;
        low_cnt = 0;
        if (cyc >= cur_lat) tr_end = 1'b1;
      end else begin
        seen = 1'b0;
        cyc = 0;
        low_cnt++;
        if (!stale_mode || low_cnt >= GAP + 2) tr_end = 1'b0;
      end
    end
  end

  typedef struct packed {
    logic st, bs, dn, er;
    logic [1:0] idx;
    logic [23:0] d;
  } exp_t;

  exp_t exp_q[$];
  bit   rs_q[$];
  bit   rs_pend = 1'b0;

  // restart in element i is sampled in the state of element i-1; random pulses
  // only land where the sequencer is busy, so they must be ignored
  function automatic void seg(input int n, input logic st, input logic bs, input logic dn,
                              input logic er, input int idx, input logic [23:0] d);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{st, bs, dn, er, 2'(idx), d});
      if (rs_pend) begin
        rs_q.push_back(1'b1);
        rs_pend = 1'b0;
      end else begin
        rs_q.push_back(bs && ($urandom_range(0, 7) == 0));
      end
    end
  endfunction

  function automatic void write_entry(input int i, input int lat);
    lat_q.push_back(lat);
    seg(2, 0, 1, 0, 0, i, word(i));
    seg(lat, 1, 1, 0, 0, i, word(i));
    seg(GAP, 0, 1, 0, 0, i, word(i));
  endfunction

  function automatic void table_run(input int fail_idx, input int tmo_idx, input int hold);
    for (int i = 0; i < 4; i++) begin
      if (i == fail_idx) begin
        lat_q.push_back(NEVER);
        seg(2, 0, 1, 0, 0, i, word(i));
        seg(TMO, 1, 1, 0, 0, i, word(i));
        seg(hold, 0, 0, 0, 1, i, word(i));
        return;
      end
      write_entry(i, (i == tmo_idx) ? TMO : int'($urandom_range(1, TMO - 1)));
    end
    seg(hold, 0, 0, 1, 0, 3, word(3));
  endfunction

  task automatic play();
    exp_t e;
    bit   r;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rs_q.pop_front();
      @(negedge mdc);
      restart = r;
      @(posedge mdc);
      #1;
      check_val("start",     32'(start),     32'(e.st));
      check_val("busy",      32'(busy),      32'(e.bs));
      check_val("done",      32'(done),      32'(e.dn));
      check_val("err",       32'(err),       32'(e.er));
      check_val("cur_idx",   32'(cur_idx),   32'(e.idx));
      check_val("mdio_data", 32'(mdio_data), 32'(e.d));
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_start"}, 32'(start),     32'd0);
    check_val({tag, "_busy"},  32'(busy),      32'd0);
    check_val({tag, "_done"},  32'(done),      32'd0);
    check_val({tag, "_err"},   32'(err),       32'd0);
    check_val({tag, "_idx"},   32'(cur_idx),   32'd0);
    check_val({tag, "_data"},  32'(mdio_data), 32'd0);
  endtask

  initial begin
    int lat1, k;
    repeat (3) @(posedge mdc);
    #1;
    check_zero("reset");
    @(posedge mdc);
    #5 reset_n = 1'b1;

    for (int it = 0; it < 3; it++) begin
      stale_mode = (it == 1);
      if (it == 0) seg(PWRUP, 0, 1, 0, 0, 0, 24'h0);
      else         rs_pend = 1'b1;
      table_run(-1, int'($urandom_range(0, 3)), int'($urandom_range(2, 6)));
      rs_pend = 1'b1;
      table_run((it == 0) ? 2 : int'($urandom_range(0, 3)), -1, int'($urandom_range(2, 6)));
      rs_pend = 1'b1;
      table_run(-1, int'($urandom_range(0, 3)), int'($urandom_range(2, 6)));
      play();
    end

    // abort during RUN of entry 1, then expect a full power-up sequence again
    stale_mode = 1'b0;
    rs_pend = 1'b1;
    write_entry(0, int'($urandom_range(1, TMO - 1)));
    lat1 = int'($urandom_range(5, TMO - 1));
    k = int'($urandom_range(1, lat1 - 1));
    lat_q.push_back(lat1);
    seg(2, 0, 1, 0, 0, 1, word(1));
    seg(k, 1, 1, 0, 0, 1, word(1));
    play();
    #5 reset_n = 1'b0;
    restart = 1'b0;
    #1;
    check_zero("abort");
    repeat (3) @(posedge mdc);
    #1;
    check_zero("abort_hold");
    @(posedge mdc);
    #5 reset_n = 1'b1;
    seg(PWRUP, 0, 1, 0, 0, 0, 24'h0);
    table_run(-1, int'($urandom_range(0, 3)), 4);
    play();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdio_init_seq.md
MDIO_INIT_SEQ -- requirements
Module: mdio_init_seq

Interface
REQ-001 Parameter PWRUP_CYC, default 2000: mdc cycles waited after reset release before the first write (100 ms at 20 kHz).
REQ-002 Parameter GAP_CYC, default 4: idle mdc cycles between consecutive writes; legal range 2..65535.
REQ-003 Parameter TMO_CYC, default 48: maximum mdc cycles in RUN before tr_end must be seen.
REQ-004 mdc  in  1  20 kHz MDIO clock; all logic on posedge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 restart  in  1  one-cycle pulse; replays the whole table from entry 0 when sampled in DONE or ERR; ignored in all other states.
REQ-007 start  out  1  level request to the MDIO write engine; low clears the engine, high runs one 24-bit write frame.
REQ-008 mdio_data  out  24  frame word to the engine: [23:21]=0, [20:16]=register address, [15:0]=register data.
REQ-009 tr_end  in  1  engine completion flag; registered on the engine's negedge mdc, high from frame bit 33 until the engine is cleared.
REQ-010 busy  out  1  high in every state except IDLE, DONE and ERR.
REQ-011 done  out  1  high in DONE only.
REQ-012 err  out  1  high in ERR only.
REQ-013 cur_idx  out  2  index of the table entry being written or last attempted.

Function
REQ-014 Internal ROM, 4 entries, indexed by cur_idx: 0 -> addr 0x00, data 0x9140; 1 -> addr 0x14, data 0x0CE2; 2 -> addr 0x1B, data 0x848B; 3 -> addr 0x00, data 0x9140.
REQ-015 States: IDLE, PWR_WAIT, LOAD, RUN, GAP, DONE, ERR; single 16-bit down-counter cnt shared by PWR_WAIT, LOAD, RUN and GAP.
REQ-016 IDLE: entered only from reset; next cycle -> PWR_WAIT with cnt=PWRUP_CYC-1.
REQ-017 PWR_WAIT: start=0; decrement cnt; at cnt==0 -> LOAD with cur_idx=0 and cnt=1.
REQ-018 LOAD: start=0 and mdio_data=ROM[cur_idx]; held exactly 2 cycles so the engine clears cyc_count and tr_end; then -> RUN with cnt=TMO_CYC-1.
REQ-019 RUN: start=1; mdio_data constant; tr_end sampled high -> GAP with cnt=GAP_CYC-1; cnt==0 with tr_end low -> ERR.
REQ-020 RUN: tr_end high and cnt==0 in the same cycle -> GAP (completion wins over timeout).
REQ-021 GAP: start=0; at cnt==0: cur_idx==3 -> DONE, else cur_idx+1 and -> LOAD with cnt=1.
REQ-022 DONE and ERR: start=0; restart -> LOAD with cur_idx=0 and cnt=1 (no power-up wait); otherwise hold.
REQ-023 tr_end is ignored in every state except RUN; a stale high tr_end in LOAD is not an error.
REQ-024 mdio_data changes only on entry to LOAD; it holds its value through LOAD, RUN and GAP.
REQ-025 A nominal write takes 2 (LOAD) + about 34 (RUN) + GAP_CYC cycles; full table after power-up is about PWRUP_CYC + 4*(36+GAP_CYC) cycles.
REQ-026 cur_idx freezes on the failing entry in ERR and holds 3 in DONE.

Reset
REQ-027 reset_n low asynchronously forces: state IDLE, cnt=0, cur_idx=0, start=0, mdio_data=0, busy=0, done=0, err=0.
REQ-028 Reset asserted mid-frame aborts it; start drops immediately and the sequence restarts from IDLE including the power-up wait after release.

Verification
REQ-029 With PWRUP_CYC=10, GAP_CYC=4 and an engine model, release reset -> start stays 0 for 10 cycles then 2 LOAD cycles; first frame carries addr 0x00, data 0x9140; busy=1.
REQ-030 Full run -> four frames in ROM order, each preceded by start low for 2+GAP_CYC cycles (first: 2); then done=1, busy=0, cur_idx=3, start=0.
REQ-031 Engine model never raises tr_end on entry 2 -> ERR exactly TMO_CYC cycles after start rose; err=1, cur_idx=2, start=0.
REQ-032 In ERR, pulse restart -> LOAD on the next cycle with cur_idx=0; no power-up wait; table completes to DONE.
REQ-033 tr_end rises on the same cycle cnt reaches 0 in RUN -> GAP, not ERR; restart pulsed while busy -> no effect.
REQ-034 Assert reset_n during RUN of entry 1 -> all outputs zero at once; after release, PWRUP_CYC wait then entry 0 again.
